png_rgb_axis_packer: RTL and testbench

//  Sits between the PNG decoder pixel output (png_rgb_o / png_rgb_valid_o) and the CNN
//  rgb_in AXI-Stream port. Packs two 24-bit RGB pixels per 48-bit beat and buffers the

---
 rtl/png_rgb_axis_packer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_png_rgb_axis_packer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/png_rgb_axis_packer.sv
// ---------------------------------------------------------------------------
// png_rgb_axis_packer
//
// Purpose:
//   Packs the 24-bit RGB pixel stream coming out of the PNG decoder into
//   48-bit AXI-Stream beats (two pixels per beat, even pixel in the low half)
//   and buffers them in a first-word-fall-through FIFO feeding the CNN rgb_in
//   port. tlast marks the final beat of each frame, computed from the frame
//   width/height latched on png_core_start_i. A registered almost-full flag
//   lets the upstream decoder throttle itself, since this block exerts no
//   backpressure on pixels.
//
// Optional feature (compile-time macro):
//   AXIS_TUSER_EN - adds output m_axis_tuser, high on the first beat of every
//                   frame (start of frame). The FIFO entry grows to 50 bits.
//
// Parameters:
//   FIFO_DEPTH - FIFO depth in beats (power of two, >= 8)
//   AF_MARGIN  - almost-full asserts at occupancy >= FIFO_DEPTH-AF_MARGIN
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   png_core_start_i    - frame start pulse, qualifies width_i/height_i
//   width_i, height_i   - frame size in pixels
//   png_rgb_i           - pixel {R,G,B}
//   png_rgb_valid_i     - pixel valid (always accepted)
//   fifo_almost_full_o  - registered almost-full flag
//   m_axis_*            - AXI-Stream master (tdata, tvalid, tready, tlast[, tuser])
//   frame_done_o        - pulse after a tlast handshake or a zero-size frame
//   err_o               - sticky error: overflow, stray pixel, aborted frame
// ---------------------------------------------------------------------------
module png_rgb_axis_packer #(
  parameter int FIFO_DEPTH = 64,
  parameter int AF_MARGIN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        png_core_start_i,
  input  logic [13:0] width_i,
  input  logic [31:0] height_i,
  input  logic [23:0] png_rgb_i,
  input  logic        png_rgb_valid_i,
  output logic        fifo_almost_full_o,
  output logic [47:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
`ifdef AXIS_TUSER_EN
  output logic        m_axis_tuser,
`endif
  output logic        frame_done_o,
  output logic        err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef AXIS_TUSER_EN
  localparam int FW = 50;
`else
  localparam int FW = 49;
`endif
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_AF = CW'(FIFO_DEPTH - AF_MARGIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVEN = 2'd1,
    S_ODD  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [31:0]     r_total;
  logic [31:0]     r_pix_cnt;
  logic [23:0]     r_held;
  logic [FW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_af;
  logic            r_done;
  logic            r_err;
`ifdef AXIS_TUSER_EN
  logic            r_sof;
`endif

  logic [31:0]     w_total;
  logic            w_last_pix;
  logic            w_wr_req;
  logic [47:0]     w_wr_data;
  logic            w_wr_last;
  logic            w_stray;
  logic            w_abort;
  logic [FW-1:0]   w_wr_entry;
  logic [FW-1:0]   w_head;
  logic            w_tvalid;
  logic            w_rd;
  logic            w_full;
  logic            w_do_wr;

  // Frames larger than 2^32 pixels are unsupported; the product is truncated.
  assign w_total    = {18'd0, width_i} * height_i;
  assign w_last_pix = ((r_pix_cnt + 32'd1) == r_total);

  // Next-state and beat-write decode for the pixel pairing FSM.
  always_comb begin
    w_next_state = r_state;
    w_wr_req     = 1'b0;
    w_wr_data    = 48'h0;
    w_wr_last    = 1'b0;
    w_stray      = 1'b0;
    w_abort      = 1'b0;
    if (png_core_start_i) begin
      // A start pre-empts any frame in flight; the held half-beat is lost.
      w_abort = (r_state != S_IDLE);
      if (w_total != 32'd0) begin
        w_next_state = S_EVEN;
      end else begin
        w_next_state = S_IDLE;
      end
    end else if (png_rgb_valid_i) begin
      case (r_state)
        S_IDLE: begin
          w_stray = 1'b1;
        end
        S_EVEN: begin
          if (w_last_pix) begin
            // Odd-length frame: final pixel goes out alone, upper half zero.
            w_wr_req     = 1'b1;
            w_wr_data    = {24'h0, png_rgb_i};
            w_wr_last    = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_ODD;
          end
        end
        S_ODD: begin
          w_wr_req  = 1'b1;
          w_wr_data = {png_rgb_i, r_held};
          w_wr_last = w_last_pix;
          if (w_last_pix) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_EVEN;
          end
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

`ifdef AXIS_TUSER_EN
  assign w_wr_entry = {r_sof, w_wr_last, w_wr_data};
`else
  assign w_wr_entry = {w_wr_last, w_wr_data};
`endif

  assign w_head   = r_mem[r_rd_ptr];
  assign w_tvalid = (r_count != {CW{1'b0}});
  assign w_rd     = w_tvalid & m_axis_tready;
  assign w_full   = (r_count == CNT_FULL);
  // A same-cycle read frees a slot, so a write into a full FIFO still lands.
  assign w_do_wr  = w_wr_req & (~w_full | w_rd);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Frame size, pixel counter and the held even pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total   <= 32'd0;
      r_pix_cnt <= 32'd0;
      r_held    <= 24'h0;
    end else if (png_core_start_i) begin
      r_total   <= w_total;
      r_pix_cnt <= 32'd0;
    end else if (png_rgb_valid_i && (r_state != S_IDLE)) begin
      r_pix_cnt <= r_pix_cnt + 32'd1;
      if (r_state == S_EVEN) begin
        r_held <= png_rgb_i;
      end
    end
  end

`ifdef AXIS_TUSER_EN
  // Start-of-frame marker, consumed by the first beat of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sof <= 1'b0;
    end else if (png_core_start_i) begin
      r_sof <= 1'b1;
    end else if (w_wr_req) begin
      r_sof <= 1'b0;
    end
  end
`endif

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Status flags: almost-full lags occupancy by a cycle; err is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_af   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_af   <= (r_count >= CNT_AF);
      r_done <= (w_rd & w_head[48]) | (png_core_start_i & (w_total == 32'd0));
      r_err  <= r_err | w_stray | w_abort | (w_wr_req & ~w_do_wr);
    end
  end

  assign fifo_almost_full_o = r_af;
  assign frame_done_o       = r_done;
  assign err_o              = r_err;
  assign m_axis_tvalid      = w_tvalid;
  assign m_axis_tdata       = w_tvalid ? w_head[47:0] : 48'h0;
  assign m_axis_tlast       = w_tvalid & w_head[48];
`ifdef AXIS_TUSER_EN
  assign m_axis_tuser       = w_tvalid & w_head[49];
`endif

endmodule

// File: tb/tb_png_rgb_axis_packer.sv
// ---------------------------------------------------------------------------
// tb_png_rgb_axis_packer
//
// Directed bench for png_rgb_axis_packer (FIFO_DEPTH=64, AF_MARGIN=4).
// Each scenario task drives its stimulus and compares observed outputs with
// hand-computed values. Handshaken beats are captured into a queue and
// frame_done pulses are counted by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_png_rgb_axis_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        png_core_start_i = 1'b0;
  logic [13:0] width_i = 14'd0;
  logic [31:0] height_i = 32'd0;
  logic [23:0] png_rgb_i = 24'h0;
  logic        png_rgb_valid_i = 1'b0;
  logic        fifo_almost_full_o;
  logic [47:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        frame_done_o;
  logic        err_o;
  logic        tuser_s;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [49:0] q [$];

  png_rgb_axis_packer #(.FIFO_DEPTH(64), .AF_MARGIN(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .png_core_start_i   (png_core_start_i),
    .width_i            (width_i),
    .height_i           (height_i),
    .png_rgb_i          (png_rgb_i),
    .png_rgb_valid_i    (png_rgb_valid_i),
    .fifo_almost_full_o (fifo_almost_full_o),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
`ifdef AXIS_TUSER_EN
    .m_axis_tuser       (tuser_s),
`endif
    .frame_done_o       (frame_done_o),
    .err_o              (err_o)
  );

`ifndef AXIS_TUSER_EN
  assign tuser_s = 1'b0;
`endif

  always #5 clk = ~clk;

  // Capture beats that will handshake on the coming posedge; count done pulses.
  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) q.push_back({tuser_s, m_axis_tlast, m_axis_tdata});
    if (frame_done_o) done_cnt++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic start_frame(input logic [13:0] w, input logic [31:0] h);
    png_core_start_i = 1'b1;
    width_i = w;
    height_i = h;
    tick(1);
    png_core_start_i = 1'b0;
  endtask

  // Leaves valid high so consecutive calls form a back-to-back burst.
  task automatic send_px(input logic [23:0] p);
    png_rgb_valid_i = 1'b1;
    png_rgb_i = p;
    tick(1);
  endtask

  task automatic idle(input int n);
    png_rgb_valid_i = 1'b0;
    tick(n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tdata !== 48'h0) begin n_err++; $display("FAIL reset_tdata got=%h exp=0", m_axis_tdata); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); end
    n_cmp++; if (fifo_almost_full_o !== 1'b0) begin n_err++; $display("FAIL reset_af got=%b exp=0", fifo_almost_full_o); end
    n_cmp++; if (frame_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", frame_done_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", err_o); end
  endtask

  task automatic test_basic_4x2();
    int qb;
    int db;
    logic [49:0] exp;
    qb = q.size();
    db = done_cnt;
    m_axis_tready = 1'b1;
    start_frame(14'd4, 32'd2);
    for (int i = 1; i <= 8; i++) send_px(24'(i));
    idle(8);
    n_cmp++; if (q.size() - qb !== 4) begin n_err++; $display("FAIL basic_beats got=%0d exp=4", q.size() - qb); end
    for (int k = 0; k < 4; k++) begin
      exp[47:0] = {24'(2 * k + 2), 24'(2 * k + 1)};
      exp[48] = (k == 3);
`ifdef AXIS_TUSER_EN
      exp[49] = (k == 0);
`else
      exp[49] = 1'b0;
`endif
      n_cmp++;
      if (qb + k >= q.size()) begin
        n_err++; $display("FAIL basic_beat%0d got=missing exp=%h", k, exp);
      end else if (q[qb + k] !== exp) begin
        n_err++; $display("FAIL basic_beat%0d got=%h exp=%h", k, q[qb + k], exp);
      end
    end
    n_cmp++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL basic_done got=%0d exp=1", done_cnt - db); end
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL basic_err got=%b exp=0", err_o); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL basic_empty got=%b exp=0", m_axis_tvalid); end
  endtask

  task automatic test_odd_3x1();
    int qb;
    int db;
    qb = q.size();
    db = done_cnt;
    start_frame(14'd3, 32'd1);
    send_px(24'hA1A1A1);
    send_px(24'hB2B2B2);
    send_px(24'hC3C3C3);
    png_rgb_valid_i = 1'b0;
    // Completing pixel written on the edge it is sampled: tvalid next cycle.
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL odd_latency got=%b exp=1", m_axis_tvalid); end
    idle(6);
    n_cmp++; if (q.size() - qb !== 2) begin n_err++; $display("FAIL odd_beats got=%0d exp=2", q.size() - qb); end
    if (q.size() - qb >= 2) begin
      n_cmp++; if (q[qb] !== {2'b00, 24'hB2B2B2, 24'hA1A1A1}) begin n_err++; $display("FAIL odd_beat0 got=%h exp=%h", q[qb], {2'b00, 24'hB2B2B2, 24'hA1A1A1}); end
      n_cmp++; if (q[qb + 1][48:0] !== {1'b1, 24'h000000, 24'hC3C3C3}) begin n_err++; $display("FAIL odd_beat1 got=%h exp=%h", q[qb + 1][48:0], {1'b1, 24'h000000, 24'hC3C3C3}); end
    end
    n_cmp++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL odd_done got=%0d exp=1", done_cnt - db); end
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL odd_err got=%b exp=0", err_o); end
  endtask

  task automatic test_overflow();
    int qb;
    do_reset();
    m_axis_tready = 1'b0;
    qb = q.size();
    start_frame(14'd140, 32'd1);
    for (int i = 1; i <= 118; i++) send_px(24'(i));
    idle(3);
    n_cmp++; if (fifo_almost_full_o !== 1'b0) begin n_err++; $display("FAIL ovf_af59 got=%b exp=0", fifo_almost_full_o); end
    send_px(24'd119);
    send_px(24'd120);
    idle(3);
    n_cmp++; if (fifo_almost_full_o !== 1'b1) begin n_err++; $display("FAIL ovf_af60 got=%b exp=1", fifo_almost_full_o); end
    for (int i = 121; i <= 128; i++) send_px(24'(i));
    idle(1);
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL ovf_err64 got=%b exp=0", err_o); end
    for (int i = 129; i <= 140; i++) send_px(24'(i));
    idle(2);
    n_cmp++; if (err_o !== 1'b1) begin n_err++; $display("FAIL ovf_err got=%b exp=1", err_o); end
    n_cmp++; if (q.size() - qb !== 0) begin n_err++; $display("FAIL ovf_nodrain got=%0d exp=0", q.size() - qb); end
    m_axis_tready = 1'b1;
    tick(80);
    n_cmp++; if (q.size() - qb !== 64) begin n_err++; $display("FAIL ovf_drain got=%0d exp=64", q.size() - qb); end
    if (q.size() - qb >= 64) begin
      n_cmp++; if (q[qb][48:0] !== {1'b0, 24'd2, 24'd1}) begin n_err++; $display("FAIL ovf_first got=%h exp=%h", q[qb][48:0], {1'b0, 24'd2, 24'd1}); end
      n_cmp++; if (q[qb + 63][48:0] !== {1'b0, 24'd128, 24'd127}) begin n_err++; $display("FAIL ovf_last got=%h exp=%h", q[qb + 63][48:0], {1'b0, 24'd128, 24'd127}); end
    end
    n_cmp++; if (fifo_almost_full_o !== 1'b0) begin n_err++; $display("FAIL ovf_af_drained got=%b exp=0", fifo_almost_full_o); end
  endtask

  task automatic test_abort();
    int qb;
    int db;
    do_reset();
    m_axis_tready = 1'b1;
    qb = q.size();
    db = done_cnt;
    start_frame(14'd4, 32'd2);
    for (int i = 1; i <= 5; i++) send_px(24'(i));
    idle(1);
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL abort_err_pre got=%b exp=0", err_o); end
    start_frame(14'd2, 32'd1);
    send_px(24'h00000B);
    send_px(24'h00000C);
    idle(6);
    n_cmp++; if (q.size() - qb !== 3) begin n_err++; $display("FAIL abort_beats got=%0d exp=3", q.size() - qb); end
    if (q.size() - qb >= 3) begin
      n_cmp++; if (q[qb][48:0] !== {1'b0, 24'd2, 24'd1}) begin n_err++; $display("FAIL abort_beat0 got=%h exp=%h", q[qb][48:0], {1'b0, 24'd2, 24'd1}); end
      n_cmp++; if (q[qb + 1][48:0] !== {1'b0, 24'd4, 24'd3}) begin n_err++; $display("FAIL abort_beat1 got=%h exp=%h", q[qb + 1][48:0], {1'b0, 24'd4, 24'd3}); end
      n_cmp++; if (q[qb + 2][48:0] !== {1'b1, 24'h00000C, 24'h00000B}) begin n_err++; $display("FAIL abort_beat2 got=%h exp=%h", q[qb + 2][48:0], {1'b1, 24'h00000C, 24'h00000B}); end
    end
    n_cmp++; if (err_o !== 1'b1) begin n_err++; $display("FAIL abort_err got=%b exp=1", err_o); end
    n_cmp++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL abort_done got=%0d exp=1", done_cnt - db); end
  endtask

  task automatic test_zero_size();
    int db;
    do_reset();
    db = done_cnt;
    start_frame(14'd0, 32'd5);
    n_cmp++; if (frame_done_o !== 1'b1) begin n_err++; $display("FAIL zero_done_pulse got=%b exp=1", frame_done_o); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL zero_tvalid got=%b exp=0", m_axis_tvalid); end
    tick(1);
    n_cmp++; if (frame_done_o !== 1'b0) begin n_err++; $display("FAIL zero_done_clear got=%b exp=0", frame_done_o); end
    tick(3);
    n_cmp++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt - db); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL zero_tvalid_late got=%b exp=0", m_axis_tvalid); end
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL zero_err got=%b exp=0", err_o); end
  endtask

  task automatic test_reset_mid_frame();
    int qb;
    int db;
    do_reset();
    m_axis_tready = 1'b0;
    send_px(24'd99);
    idle(1);
    n_cmp++; if (err_o !== 1'b1) begin n_err++; $display("FAIL stray_err got=%b exp=1", err_o); end
    start_frame(14'd4, 32'd2);
    for (int i = 1; i <= 6; i++) send_px(24'(i));
    idle(2);
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_tvalid got=%b exp=1", m_axis_tvalid); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got=%b exp=0", m_axis_tvalid); end
    n_cmp++; if (err_o !== 1'b0) begin n_err++; $display("FAIL rstmid_err got=%b exp=0", err_o); end
    tick(1);
    m_axis_tready = 1'b1;
    qb = q.size();
    db = done_cnt;
    start_frame(14'd2, 32'd1);
    send_px(24'h000015);
    send_px(24'h000016);
    idle(6);
    n_cmp++; if (q.size() - qb !== 1) begin n_err++; $display("FAIL rstmid_beats got=%0d exp=1", q.size() - qb); end
    if (q.size() - qb >= 1) begin
      n_cmp++; if (q[qb][48:0] !== {1'b1, 24'h000016, 24'h000015}) begin n_err++; $display("FAIL rstmid_beat got=%h exp=%h", q[qb][48:0], {1'b1, 24'h000016, 24'h000015}); end
    end
    n_cmp++; if (done_cnt - db !== 1) begin n_err++; $display("FAIL rstmid_done got=%0d exp=1", done_cnt - db); end
  endtask

  initial begin
    test_reset();
    test_basic_4x2();
    test_odd_3x1();
    test_overflow();
    test_abort();
    test_zero_size();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
